nisc_seq: RTL and testbench
===========================

Name: nisc_seq

Overview:
- Upstream control sequencer for the NISC datapath.
- Fetches fixed-format control words from a synchronous program ROM.
- Drives the write enable, write data and address ports of the 2-entry general-purpose register file, and consumes its registered read data.
- Holds the accumulator and carry flag, resolves branches, and presents results on a valid/ready output port.

Parameters:
- n, 8, datapath width; matches register file width.
- Rsize, 1, register address width; 2^Rsize registers.
- Psize, 6, program address width; must satisfy Psize <= n.

Ports:
- clk  in  1  clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- start  in  1  begin execution from pc 0; honoured only in IDLE or HALTED.
- pc_addr  out  Psize  program ROM address; equals pc register.
- cw  in  4+Rsize+n  control word from ROM, valid the cycle after pc_addr is presented.
- reg_w  out  1  register file write enable.
- reg_Wdata  out  n  register file write data.
- reg_Raddr  out  Rsize  register file address, shared by read and write.
- reg_Rdata  in  n  register file read data, valid 1 cycle after reg_Raddr is sampled.
- out_data  out  n  output value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- acc  out  n  accumulator.
- carry  out  1  carry/borrow flag.
- halted  out  1  high in HALTED.

Behaviour:
- Control word fields: op = cw[3+Rsize+n : Rsize+n], ra = cw[Rsize+n-1 : n], imm = cw[n-1:0]. Branch target = imm[Psize-1:0].
- Reset (async, nReset=0) values: state=IDLE, pc=0, acc=0, carry=0, out_data=0, out_valid=0, halted=0, reg_w=0, reg_Wdata=0, reg_Raddr=0. Reset asserted mid-instruction aborts it with no further register write.
- States: IDLE, FETCH, EXEC, RDWAIT, OUTWAIT, HALTED.
  - IDLE --start--> FETCH with pc=0.
  - FETCH: always goes to EXEC. The ROM samples pc_addr on the edge ending FETCH.
  - EXEC: cw is valid. Latch it into ir; later states use ir. Decode per op.
- Op codes:
  - 0 NOP: pc+1.
  - 1 LDI: acc=imm.
  - 2 LD: acc=R[ra].
  - 3 ST: R[ra]=acc.
  - 4 ADD: acc=acc+R[ra].
  - 5 SUB: acc=acc-R[ra].
  - 6 AND: acc&R[ra].
  - 7 XOR: acc^R[ra].
  - 8 ADDI: acc+imm.
  - 9 JMP.
  - A JZ: taken if acc==0.
  - B JC: taken if carry==1.
  - C OUT.
  - D HALT.
  - E, F: treated as NOP.
- Register access (reg_w, reg_Raddr, reg_Wdata decoded combinationally from cw in EXEC; otherwise reg_w=0, reg_Raddr=ir.ra, reg_Wdata=acc):
  - Ops 2, 4-7: in EXEC drive reg_Raddr=ra, reg_w=0, then go to RDWAIT. RDWAIT computes from reg_Rdata, does pc+1, goes to FETCH. Total 3 cycles.
  - ST: in EXEC drive reg_w=1, reg_Raddr=ra, reg_Wdata=acc for exactly one cycle. Total 2 cycles.
- Arithmetic:
  - ADD/ADDI: carry = bit n of the (n+1)-bit sum; acc = low n bits.
  - SUB: carry = 1 iff acc < operand (borrow); acc = difference mod 2^n.
  - Other ops leave carry unchanged. Overflow wraps silently.
- Sequencing:
  - Non-read ops (0, 1, 3, 8, 9, A, B, E, F) complete in EXEC, then go to FETCH. 2 cycles each.
  - Branch taken: pc=target; otherwise pc+1.
  - pc increments modulo 2^Psize; 2^Psize-1 wraps to 0.
- OUT:
  - EXEC loads out_data=acc and sets out_valid=1, then goes to OUTWAIT.
  - OUTWAIT holds out_valid and out_data stable until out_valid&&out_ready. On that edge: out_valid=0, pc+1, FETCH.
  - out_ready high while in EXEC does not shorten the sequence; minimum 3 cycles.
- HALT:
  - HALTED with halted=1; pc, acc and carry are held.
  - start in HALTED: pc=0, halted=0, FETCH; acc and carry preserved.
  - start in FETCH/EXEC/RDWAIT/OUTWAIT is ignored.

Test Plan:
1. Reset, start; program LDI 5, ST R1, LDI 0, LD R1, OUT, HALT; out_ready=1 -> exactly one reg_w pulse (addr 1, data 0x05); out_data=0x05; halted=1 after 2+2+2+3+3+2 cycles.
2. LDI 0xF0, ST R0, LDI 0x20, ADD R0, JC 8 -> acc=0x10, carry=1, next pc_addr=8.
3. LDI 5, ST R1, LDI 3, SUB R1, JZ 0 -> acc=0xFE, carry=1, JZ not taken, pc advances by 1.
4. OUT with out_ready low for 4 cycles, then high -> out_valid held 5 cycles, out_data stable, pc_addr unchanged until the handshake edge.
5. JMP 63; NOP at address 63 -> following fetch presents pc_addr=0; reg_w stays 0 throughout.
6. nReset pulsed low during OUTWAIT -> out_valid=0 immediately, pc_addr=0, acc=0; no activity until start.

Source files
------------

// File: rtl/nisc_seq.sv
// Control sequencer for the NISC datapath: fetches control words from a synchronous ROM,
// drives the register file, holds acc/carry, resolves branches and emits results via valid/ready.
module nisc_seq #(
  parameter int unsigned n     = 8,
  parameter int unsigned Rsize = 1,
  parameter int unsigned Psize = 6
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   start,
  output logic [Psize-1:0]       pc_addr,
  input  logic [4+Rsize+n-1:0]   cw,
  output logic                   reg_w,
  output logic [n-1:0]           reg_Wdata,
  output logic [Rsize-1:0]       reg_Raddr,
  input  logic [n-1:0]           reg_Rdata,
  output logic [n-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [n-1:0]           acc,
  output logic                   carry,
  output logic                   halted
);

  localparam int unsigned CW_W = 4 + Rsize + n;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, RDWAIT, OUTWAIT, HALTED} state_t;

  state_t             state_q, state_d;
  logic [Psize-1:0]   pc_q, pc_d;
  logic [n-1:0]       acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [n-1:0]       out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               halted_q, halted_d;
  // Only op and ra of the latched word are needed after EXEC.
  logic [3:0]         ir_op_q, ir_op_d;
  logic [Rsize-1:0]   ir_ra_q, ir_ra_d;

  logic [3:0]         cw_op;
  logic [Rsize-1:0]   cw_ra;
  logic [n-1:0]       cw_imm;
  logic [Psize-1:0]   target;
  logic [Psize-1:0]   pc_inc;
  logic [n:0]         sum_imm, sum_reg, diff_reg;

  assign cw_op    = cw[CW_W-1 -: 4];
  assign cw_ra    = cw[n +: Rsize];
  assign cw_imm   = cw[n-1:0];
  assign target   = cw_imm[Psize-1:0];
  assign pc_inc   = pc_q + Psize'(1);
  assign sum_imm  = {1'b0, acc_q} + {1'b0, cw_imm};
  assign sum_reg  = {1'b0, acc_q} + {1'b0, reg_Rdata};
  // Bit n of the extended difference is the borrow.
  assign diff_reg = {1'b0, acc_q} - {1'b0, reg_Rdata};

  // State and datapath registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      ir_op_q     <= '0;
      ir_ra_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      ir_op_q     <= ir_op_d;
      ir_ra_q     <= ir_ra_d;
    end
  end

  // Next-state, datapath update and register-file port decode
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    ir_op_d     = ir_op_q;
    ir_ra_d     = ir_ra_q;
    reg_w       = 1'b0;
    reg_Raddr   = ir_ra_q;
    reg_Wdata   = acc_q;

    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d  = FETCH;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        ir_op_d   = cw_op;
        ir_ra_d   = cw_ra;
        reg_Raddr = cw_ra;
        state_d   = FETCH;
        pc_d      = pc_inc;
        case (cw_op)
          OP_LDI:  acc_d = cw_imm;
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            state_d = RDWAIT;
            pc_d    = pc_q;
          end
          OP_ST:   reg_w = 1'b1;
          OP_ADDI: {carry_d, acc_d} = sum_imm;
          OP_JMP:  pc_d = target;
          OP_JZ:   if (acc_q == '0) pc_d = target;
          OP_JC:   if (carry_q) pc_d = target;
          OP_OUT: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            state_d     = OUTWAIT;
            pc_d        = pc_q;
          end
          OP_HALT: begin
            state_d  = HALTED;
            halted_d = 1'b1;
            pc_d     = pc_q;
          end
          default: ;
        endcase
      end
      RDWAIT: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (ir_op_q)
          OP_LD:   acc_d = reg_Rdata;
          OP_ADD:  {carry_d, acc_d} = sum_reg;
          OP_SUB:  {carry_d, acc_d} = diff_reg;
          OP_AND:  acc_d = acc_q & reg_Rdata;
          OP_XOR:  acc_d = acc_q ^ reg_Rdata;
          default: ;
        endcase
      end
      OUTWAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_addr   = pc_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_nisc_seq.sv
// Directed bench for nisc_seq with a behavioural synchronous ROM and 2-entry register file.
module tb_nisc_seq;

  localparam int unsigned N    = 8;
  localparam int unsigned RS   = 1;
  localparam int unsigned PS   = 6;
  localparam int unsigned CW_W = 4 + RS + N;

  logic              clk = 1'b0;
  logic              nReset;
  logic              start;
  logic [PS-1:0]     pc_addr;
  logic [CW_W-1:0]   cw;
  logic              reg_w;
  logic [N-1:0]      reg_Wdata;
  logic [RS-1:0]     reg_Raddr;
  logic [N-1:0]      reg_Rdata;
  logic [N-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      acc;
  logic              carry;
  logic              halted;

  logic [CW_W-1:0]   rom [0:63];
  logic [N-1:0]      rf  [0:1];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int hs_cnt = 0;
  logic [RS-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic [N-1:0]  hs_data;

  always #5 clk = ~clk;

  nisc_seq #(.n(N), .Rsize(RS), .Psize(PS)) dut (
    .clk(clk), .nReset(nReset), .start(start), .pc_addr(pc_addr), .cw(cw),
    .reg_w(reg_w), .reg_Wdata(reg_Wdata), .reg_Raddr(reg_Raddr), .reg_Rdata(reg_Rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .carry(carry), .halted(halted)
  );

  always @(posedge clk) cw <= rom[pc_addr];

  always @(posedge clk) begin
    if (reg_w) rf[reg_Raddr] <= reg_Wdata;
    reg_Rdata <= rf[reg_Raddr];
  end

  // Record register writes and output handshakes mid-cycle
  always @(negedge clk) begin
    if (reg_w) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = reg_Raddr;
      wr_data = reg_Wdata;
    end
    if (out_valid && out_ready) begin
      hs_cnt  = hs_cnt + 1;
      hs_data = out_data;
    end
  end

  function automatic logic [CW_W-1:0] mk(input logic [3:0] op, input logic ra, input logic [7:0] imm);
    return {op, ra, imm};
  endfunction

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    tick(2);
    nReset = 1'b1;
    tick(1);
    for (int i = 0; i < 64; i++) rom[i] = mk(4'hD, 1'b0, 8'h00);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    tick(2);
    checks++; if (pc_addr !== 6'd0) begin errors++; $display("FAIL rst_pc got %h want 00", pc_addr); end
    checks++; if ({acc, carry} !== 9'd0) begin errors++; $display("FAIL rst_acc_carry got %h/%b want 00/0", acc, carry); end
    checks++; if ({out_valid, out_data, halted} !== 10'd0) begin errors++; $display("FAIL rst_out got v=%b d=%h h=%b want 0/00/0", out_valid, out_data, halted); end
    checks++; if ({reg_w, reg_Raddr, reg_Wdata} !== 10'd0) begin errors++; $display("FAIL rst_regport got w=%b a=%h d=%h want 0/0/00", reg_w, reg_Raddr, reg_Wdata); end
    nReset = 1'b1;
    tick(3);
    checks++; if (pc_addr !== 6'd0 || halted !== 1'b0) begin errors++; $display("FAIL rst_idle got pc=%h h=%b want 00/0", pc_addr, halted); end
  endtask

  task automatic test_ld_st_out();
    int w0, h0;
    do_reset();
    rom[0] = mk(4'h1, 1'b0, 8'h05);
    rom[1] = mk(4'h3, 1'b1, 8'h00);
    rom[2] = mk(4'h1, 1'b0, 8'h00);
    rom[3] = mk(4'h2, 1'b1, 8'h00);
    rom[4] = mk(4'hC, 1'b0, 8'h00);
    rom[5] = mk(4'hD, 1'b0, 8'h00);
    w0 = wr_cnt; h0 = hs_cnt;
    pulse_start();
    tick(13);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL t1_early_halt got %b want 0", halted); end
    tick(1);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL t1_halt got %b want 1", halted); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL t1_wr_cnt got %0d want 1", wr_cnt - w0); end
    checks++; if (wr_addr !== 1'b1 || wr_data !== 8'h05) begin errors++; $display("FAIL t1_wr got a=%h d=%h want 1/05", wr_addr, wr_data); end
    checks++; if (hs_cnt - h0 !== 1 || hs_data !== 8'h05) begin errors++; $display("FAIL t1_out got n=%0d d=%h want 1/05", hs_cnt - h0, hs_data); end
    checks++; if (pc_addr !== 6'd5 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_halt_pc got pc=%h v=%b want 05/0", pc_addr, out_valid); end
    pulse_start();
    checks++; if (pc_addr !== 6'd0 || halted !== 1'b0 || acc !== 8'h05) begin errors++; $display("FAIL t1_restart got pc=%h h=%b acc=%h want 00/0/05", pc_addr, halted, acc); end
  endtask

  task automatic test_add_carry();
    do_reset();
    rom[0] = mk(4'h1, 1'b0, 8'hF0);
    rom[1] = mk(4'h3, 1'b0, 8'h00);
    rom[2] = mk(4'h1, 1'b0, 8'h20);
    rom[3] = mk(4'h4, 1'b0, 8'h00);
    rom[4] = mk(4'hB, 1'b0, 8'h08);
    rom[8] = mk(4'h8, 1'b0, 8'hF5);
    rom[9] = mk(4'h8, 1'b0, 8'h01);
    pulse_start();
    tick(11);
    checks++; if (pc_addr !== 6'd8) begin errors++; $display("FAIL t2_jc_pc got %h want 08", pc_addr); end
    checks++; if (acc !== 8'h10 || carry !== 1'b1) begin errors++; $display("FAIL t2_add got %h/%b want 10/1", acc, carry); end
    tick(2);
    checks++; if (acc !== 8'h05 || carry !== 1'b1) begin errors++; $display("FAIL t2_addi1 got %h/%b want 05/1", acc, carry); end
    tick(2);
    checks++; if (acc !== 8'h06 || carry !== 1'b0) begin errors++; $display("FAIL t2_addi2 got %h/%b want 06/0", acc, carry); end
  endtask

  task automatic test_sub_logic();
    do_reset();
    rom[0] = mk(4'h1, 1'b0, 8'h05);
    rom[1] = mk(4'h3, 1'b1, 8'h00);
    rom[2] = mk(4'h1, 1'b0, 8'h03);
    rom[3] = mk(4'h5, 1'b1, 8'h00);
    rom[4] = mk(4'hA, 1'b0, 8'h00);
    rom[5] = mk(4'h6, 1'b1, 8'h00);
    rom[6] = mk(4'h7, 1'b1, 8'h00);
    rom[7] = mk(4'h8, 1'b0, 8'hFF);
    rom[8] = mk(4'hA, 1'b0, 8'h14);
    rom[9] = mk(4'h1, 1'b0, 8'h77);
    pulse_start();
    tick(9);
    checks++; if (acc !== 8'hFE || carry !== 1'b1) begin errors++; $display("FAIL t3_sub got %h/%b want FE/1", acc, carry); end
    tick(2);
    checks++; if (pc_addr !== 6'd5) begin errors++; $display("FAIL t3_jz_nt got %h want 05", pc_addr); end
    tick(3);
    checks++; if (acc !== 8'h04 || carry !== 1'b1) begin errors++; $display("FAIL t3_and got %h/%b want 04/1", acc, carry); end
    tick(3);
    checks++; if (acc !== 8'h01) begin errors++; $display("FAIL t3_xor got %h want 01", acc); end
    tick(2);
    checks++; if (acc !== 8'h00 || carry !== 1'b1) begin errors++; $display("FAIL t3_addi_wrap got %h/%b want 00/1", acc, carry); end
    tick(2);
    checks++; if (pc_addr !== 6'h14) begin errors++; $display("FAIL t3_jz_taken got %h want 14", pc_addr); end
    tick(2);
    checks++; if (halted !== 1'b1 || acc !== 8'h00) begin errors++; $display("FAIL t3_end got h=%b acc=%h want 1/00", halted, acc); end
  endtask

  task automatic test_out_backpressure();
    int h0;
    do_reset();
    rom[0] = mk(4'h1, 1'b0, 8'h5A);
    rom[1] = mk(4'hC, 1'b0, 8'h00);
    out_ready = 1'b0;
    h0 = hs_cnt;
    pulse_start();
    tick(4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || pc_addr !== 6'd1) begin errors++; $display("FAIL t4_hold%0d got v=%b d=%h pc=%h want 1/5A/01", i, out_valid, out_data, pc_addr); end
      start = (i == 1);
      tick(1);
      start = 1'b0;
    end
    checks++; if (out_valid !== 1'b1 || pc_addr !== 6'd1) begin errors++; $display("FAIL t4_cycle5 got v=%b pc=%h want 1/01", out_valid, pc_addr); end
    out_ready = 1'b1;
    tick(1);
    checks++; if (out_valid !== 1'b0 || pc_addr !== 6'd2 || hs_cnt - h0 !== 1) begin errors++; $display("FAIL t4_hs got v=%b pc=%h n=%0d want 0/02/1", out_valid, pc_addr, hs_cnt - h0); end
    tick(2);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL t4_halt got %b want 1", halted); end
  endtask

  task automatic test_pc_wrap();
    int w0;
    do_reset();
    rom[0]  = mk(4'h9, 1'b0, 8'h3F);
    rom[63] = mk(4'h0, 1'b0, 8'h00);
    w0 = wr_cnt;
    pulse_start();
    tick(2);
    checks++; if (pc_addr !== 6'd63) begin errors++; $display("FAIL t5_jmp got %h want 3F", pc_addr); end
    tick(2);
    checks++; if (pc_addr !== 6'd0) begin errors++; $display("FAIL t5_wrap got %h want 00", pc_addr); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL t5_no_write got %0d writes want 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_in_outwait();
    int w0, h0;
    do_reset();
    rom[0] = mk(4'h1, 1'b0, 8'h33);
    rom[1] = mk(4'hC, 1'b0, 8'h00);
    out_ready = 1'b0;
    pulse_start();
    tick(4);
    checks++; if (out_valid !== 1'b1 || acc !== 8'h33) begin errors++; $display("FAIL t6_pre got v=%b acc=%h want 1/33", out_valid, acc); end
    w0 = wr_cnt; h0 = hs_cnt;
    #2 nReset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || pc_addr !== 6'd0 || acc !== 8'h00 || out_data !== 8'h00) begin errors++; $display("FAIL t6_async got v=%b pc=%h acc=%h d=%h want 0/00/00/00", out_valid, pc_addr, acc, out_data); end
    #2 nReset = 1'b1;
    out_ready = 1'b1;
    tick(5);
    checks++; if (pc_addr !== 6'd0 || out_valid !== 1'b0 || halted !== 1'b0 || wr_cnt !== w0 || hs_cnt !== h0) begin errors++; $display("FAIL t6_quiet got pc=%h v=%b h=%b dw=%0d dh=%0d want 00/0/0/0/0", pc_addr, out_valid, halted, wr_cnt - w0, hs_cnt - h0); end
  endtask

  initial begin
    rf[0] = '0;
    rf[1] = '0;
    for (int i = 0; i < 64; i++) rom[i] = mk(4'hD, 1'b0, 8'h00);
    test_reset();
    test_ld_st_out();
    test_add_carry();
    test_sub_logic();
    test_out_backpressure();
    test_pc_wrap();
    test_reset_in_outwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
